da_input_slicer: RTL and testbench

DA_INPUT_SLICER -- requirements
Module: da_input_slicer

---
 rtl/da_input_slicer_pkg.sv | 24 ++
 rtl/da_input_slicer_if.sv | 31 +++
 rtl/da_tap_bank.sv | 39 +++
 rtl/da_input_slicer.sv | 89 ++++++++
 tb/tb_da_input_slicer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/da_input_slicer_pkg.sv
// Shared definitions for the distributed-arithmetic input slicer and its DA stage:
// default geometry, FSM state encodings and slice helpers.
package da_input_slicer_pkg;

    localparam int DA_BW         = 16;
    localparam int DA_NTAPS      = 64;
    localparam int DA_GROUPS     = 8;
    localparam int DA_GROUP_BITS = 8;

    typedef logic [1:0] da_state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_EMIT      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    // Address group k carries tap bits 8k..8k+7, so tap index equals packed bit index.
    function automatic logic [DA_GROUP_BITS-1:0] da_group(
        input logic [DA_NTAPS-1:0] slice,
        input int                  k
    );
        return slice[k*DA_GROUP_BITS +: DA_GROUP_BITS];
    endfunction

endpackage

// File: rtl/da_input_slicer_if.sv
// Sample handshake on one side, bit-slice ROM addresses and DA handshake on the other.
interface da_input_slicer_if #(
    parameter int BW = da_input_slicer_pkg::DA_BW
);
    logic signed [BW-1:0] x_in;
    logic                 x_valid;
    logic                 x_ready;
    logic [7:0]           A0;
    logic [7:0]           A1;
    logic [7:0]           A2;
    logic [7:0]           A3;
    logic [7:0]           A4;
    logic [7:0]           A5;
    logic [7:0]           A6;
    logic [7:0]           A7;
    logic                 slice_valid;
    logic                 start;
    logic                 msb_slice;
    logic                 done;

    modport master (
        input  x_in, x_valid, done,
        output x_ready, A0, A1, A2, A3, A4, A5, A6, A7, slice_valid, start, msb_slice
    );

    modport slave (
        output x_in, x_valid, done,
        input  x_ready, A0, A1, A2, A3, A4, A5, A6, A7, slice_valid, start, msb_slice
    );

endinterface

// File: rtl/da_tap_bank.sv
// Sample delay line that shifts on accept and exposes one bit column (bit_sel) of all taps.
module da_tap_bank
    import da_input_slicer_pkg::*;
#(
    parameter  int BW    = DA_BW,
    parameter  int NTAPS = DA_NTAPS,
    localparam int BIT_W = $clog2(BW)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shift_en,
    input  logic signed [BW-1:0] x_in,
    input  logic [BIT_W-1:0]     bit_sel,
    output logic [NTAPS-1:0]     slice
);

    logic signed [BW-1:0] taps [NTAPS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                taps[i] <= '0;
            end
        end else if (shift_en) begin
            taps[0] <= x_in;
            for (int i = 1; i < NTAPS; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    always_comb begin
        slice = '0;
        for (int i = 0; i < NTAPS; i++) begin
            slice[i] = taps[i][bit_sel];
        end
    end

endmodule

// File: rtl/da_input_slicer.sv
// Accepts one sample, then streams its delay line to the DA stage one bit-slice per
// cycle, MSB first, and waits for the DA stage to finish before taking the next sample.
module da_input_slicer
    import da_input_slicer_pkg::*;
#(
    parameter int BW    = DA_BW,
    parameter int NTAPS = DA_NTAPS
) (
    input logic              clk,
    input logic              reset,
    da_input_slicer_if.master bus
);

    localparam int              BIT_W = $clog2(BW);
    localparam logic [BIT_W-1:0] B_TOP = BIT_W'(BW - 1);

    da_state_t          state;
    logic [BIT_W-1:0]   b;
    logic               accept;
    logic               emitting;
    logic [NTAPS-1:0]   slice;
    logic [NTAPS-1:0]   slice_out;

    assign accept   = bus.x_valid && (state == ST_IDLE);
    assign emitting = (state == ST_EMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            b     <= B_TOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EMIT;
                        b     <= B_TOP;
                    end
                end
                ST_EMIT: begin
                    if (b == '0) begin
                        state <= ST_WAIT_DONE;
                        b     <= B_TOP;
                    end else begin
                        b <= b - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    // done only counts here, so an early pulse cannot cut emission short
                    if (bus.done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    b     <= B_TOP;
                end
            endcase
        end
    end

    da_tap_bank #(
        .BW    (BW),
        .NTAPS (NTAPS)
    ) u_tap_bank (
        .clk      (clk),
        .reset    (reset),
        .shift_en (accept),
        .x_in     (bus.x_in),
        .bit_sel  (b),
        .slice    (slice)
    );

    assign slice_out = emitting ? slice : '0;

    assign bus.x_ready     = (state == ST_IDLE);
    assign bus.slice_valid = emitting;
    assign bus.start       = emitting && (b == B_TOP);
    assign bus.msb_slice   = emitting && (b == B_TOP);

    assign bus.A0 = da_group(slice_out, 0);
    assign bus.A1 = da_group(slice_out, 1);
    assign bus.A2 = da_group(slice_out, 2);
    assign bus.A3 = da_group(slice_out, 3);
    assign bus.A4 = da_group(slice_out, 4);
    assign bus.A5 = da_group(slice_out, 5);
    assign bus.A6 = da_group(slice_out, 6);
    assign bus.A7 = da_group(slice_out, 7);

endmodule

// File: tb/tb_da_input_slicer.sv
// Directed bench for da_input_slicer: reset, slice streaming, done handshake, mid-sample reset.
module tb_da_input_slicer;

    logic clk;
    logic reset;

    da_input_slicer_if #(.BW(16)) bus ();

    da_input_slicer #(
        .BW    (16),
        .NTAPS (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [15:0] mtap [64];
    logic [63:0] a_all;

    assign a_all = {bus.A7, bus.A6, bus.A5, bus.A4, bus.A3, bus.A2, bus.A1, bus.A0};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mtap[i] = 16'h0000;
    endtask

    function automatic logic [63:0] model_slice(input int bit_idx);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = mtap[i][bit_idx];
        return r;
    endfunction

    task automatic accept(input string tag, input logic [15:0] val);
        check({tag, "_ready"}, 64'(bus.x_ready), 64'd1);
        bus.x_valid = 1'b1;
        bus.x_in    = val;
        tick();
        bus.x_valid = 1'b0;
        for (int i = 63; i > 0; i--) mtap[i] = mtap[i-1];
        mtap[0] = val;
    endtask

    task automatic emit_check(input string tag);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_valid"}, 64'(bus.slice_valid), 64'd1);
            check({tag, "_start"}, 64'(bus.start), 64'(i == 0));
            check({tag, "_msb"},   64'(bus.msb_slice), 64'(i == 0));
            check({tag, "_busy"},  64'(bus.x_ready), 64'd0);
            check({tag, "_addr"},  a_all, model_slice(15 - i));
            tick();
        end
    endtask

    task automatic finish_done(input string tag);
        check({tag, "_wait_valid"}, 64'(bus.slice_valid), 64'd0);
        check({tag, "_wait_ready"}, 64'(bus.x_ready), 64'd0);
        check({tag, "_wait_addr"},  a_all, 64'd0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check({tag, "_ready_after_done"}, 64'(bus.x_ready), 64'd1);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.x_valid = 1'b0;
        bus.x_in    = '0;
        bus.done    = 1'b0;
        model_clear();

        // reset state
        repeat (3) tick();
        check("rst_valid", 64'(bus.slice_valid), 64'd0);
        check("rst_addr",  a_all, 64'd0);
        check("rst_start", 64'(bus.start), 64'd0);
        reset = 1'b0;
        tick();
        check("rst_ready", 64'(bus.x_ready), 64'd1);
        check("rst_msb",   64'(bus.msb_slice), 64'd0);

        // most negative sample: only tap0's sign bit appears, on the first slice
        accept("s8000", 16'h8000);
        check("s8000_first_addr", a_all, 64'h0000_0000_0000_0001);
        emit_check("s8000");
        finish_done("s8000");

        // -1 into empty taps, with an early done that must be ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        tick();
        accept("sffff", 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            check("sffff_addr",  a_all, 64'h0000_0000_0000_0001);
            check("sffff_msb",   64'(bus.msb_slice), 64'(i == 0));
            check("sffff_valid", 64'(bus.slice_valid), 64'd1);
            bus.done = (i == 4);
            tick();
        end
        bus.done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("early_done_still_waiting", 64'(bus.x_ready), 64'd0);
            check("early_done_no_slice", 64'(bus.slice_valid), 64'd0);
            tick();
        end
        finish_done("sffff");

        // x_valid held high through emission and wait: exactly one accept
        bus.x_valid = 1'b1;
        bus.x_in    = 16'h0002;
        tick();
        for (int i = 63; i > 0; i--) mtap[i] = mtap[i-1];
        mtap[0] = 16'h0002;
        emit_check("hold");
        repeat (2) begin
            check("hold_wait_ready", 64'(bus.x_ready), 64'd0);
            tick();
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("hold_ready_after_done", 64'(bus.x_ready), 64'd1);
        bus.x_valid = 1'b0;
        tick();

        // reset at the 5th EMIT cycle aborts the sample and clears the taps
        accept("s00f0", 16'h00F0);
        for (int i = 0; i < 4; i++) begin
            check("abort_pre_addr", a_all, model_slice(15 - i));
            tick();
        end
        check("abort_in_emit", 64'(bus.slice_valid), 64'd1);
        reset = 1'b1;
        tick();
        check("abort_valid", 64'(bus.slice_valid), 64'd0);
        check("abort_start", 64'(bus.start), 64'd0);
        check("abort_addr",  a_all, 64'd0);
        reset = 1'b0;
        model_clear();
        tick();
        check("abort_ready", 64'(bus.x_ready), 64'd1);

        // reset wins over a simultaneous accept
        reset       = 1'b1;
        bus.x_valid = 1'b1;
        bus.x_in    = 16'h7FFF;
        tick();
        reset       = 1'b0;
        bus.x_valid = 1'b0;
        check("rst_accept_valid", 64'(bus.slice_valid), 64'd0);
        tick();
        check("rst_accept_valid2", 64'(bus.slice_valid), 64'd0);
        accept("s5555", 16'h5555);
        check("s5555_first_addr", a_all, 64'd0);
        emit_check("s5555");
        finish_done("s5555");

        // 64 samples of +1 fill every tap: only the LSB slice is all ones
        for (int n = 1; n <= 64; n++) begin
            accept("fill", 16'h0001);
            if (n < 64) begin
                repeat (16) tick();
                bus.done = 1'b1;
                tick();
                bus.done = 1'b0;
            end else begin
                for (int i = 0; i < 16; i++) begin
                    check("fill_addr", a_all, (i == 15) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
                    tick();
                end
                finish_done("fill");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
